// File: rtl/ksa_shuffle_engine_if.sv
// Request/status and S/key memory-port bundle between the RC4 key-scheduling engine and its surroundings.
interface ksa_shuffle_engine_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned KEY_W  = 8,
  parameter int unsigned KLW    = 6
);
  logic              start;
  logic              init_en;
  logic [KLW-1:0]    key_len;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] s_wrdata;
  logic              s_wren;
  logic [ADDR_W-1:0] s_rddata;
  logic [KLW-1:0]    key_addr;
  logic [KEY_W-1:0]  key_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, init_en, key_len, s_rddata, key_data,
    output s_addr, s_wrdata, s_wren, key_addr, busy, done
  );

  modport slave (
    output start, init_en, key_len, s_rddata, key_data,
    input  s_addr, s_wrdata, s_wren, key_addr, busy, done
  );
endinterface

// File: rtl/ksa_shuffle_engine.sv
// RC4 key-scheduling engine: optional identity fill of S, then the i/j/k swap loop
// over a run-time key length, driving the S-memory and key-memory ports directly.
module ksa_shuffle_engine #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned KEY_W       = 8,
  parameter int unsigned KEY_LEN_MAX = 32
) (
  input logic clk,
  input logic rst,
  ksa_shuffle_engine_if.master bus
);
  localparam int unsigned KLW = $clog2(KEY_LEN_MAX + 1);
  localparam int unsigned IW  = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_SI,
    STR_SI_J,
    RD_SJ,
    STR_SJ_WR_SI,
    WR_SJ,
    NEXT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     i_q;
  logic [ADDR_W-1:0] j_q, si_q, sj_q;
  logic [KLW-1:0]    k_q, klen_q;

  logic [KLW-1:0]    klen_c, k_next_c;
  logic [IW-1:0]     i_inc_c;
  logic              i_last_c;
  logic [KEY_W-1:0]  key_byte_c;
  logic [ADDR_W-1:0] s_addr_c, s_wrdata_c;
  logic [KLW-1:0]    key_addr_c;
  logic              s_wren_c, busy_c, done_c;

  // A zero length behaves as one byte; oversize lengths saturate at the memory depth.
  always_comb begin
    if (bus.key_len == '0) begin
      klen_c = KLW'(1);
    end else if (bus.key_len > KLW'(KEY_LEN_MAX)) begin
      klen_c = KLW'(KEY_LEN_MAX);
    end else begin
      klen_c = bus.key_len;
    end
  end

  assign key_byte_c = bus.key_data;
  assign i_inc_c    = i_q + IW'(1);
  assign i_last_c   = (i_q[ADDR_W-1:0] == {ADDR_W{1'b1}});
  assign k_next_c   = (k_q == klen_q - KLW'(1)) ? '0 : k_q + KLW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (bus.start) state_d = bus.init_en ? INIT : RD_SI;
      INIT:         if (i_last_c) state_d = RD_SI;
      RD_SI:        state_d = STR_SI_J;
      STR_SI_J:     state_d = RD_SJ;
      RD_SJ:        state_d = STR_SJ_WR_SI;
      STR_SJ_WR_SI: state_d = WR_SJ;
      WR_SJ:        state_d = NEXT;
      NEXT:         state_d = i_inc_c[ADDR_W] ? DONE : RD_SI;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // i/j/k loop registers and the two captured S values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      si_q   <= '0;
      sj_q   <= '0;
      klen_q <= KLW'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            klen_q <= klen_c;
          end
        end
        INIT: i_q <= i_last_c ? '0 : i_inc_c;
        STR_SI_J: begin
          si_q <= bus.s_rddata;
          j_q  <= j_q + bus.s_rddata + ADDR_W'(key_byte_c);
        end
        STR_SJ_WR_SI: sj_q <= bus.s_rddata;
        NEXT: begin
          i_q <= i_inc_c;
          k_q <= k_next_c;
        end
        default: ;
      endcase
    end
  end

  // Port decode; both swap writes use pre-swap registers so j==i leaves S[i] intact.
  always_comb begin
    s_addr_c   = '0;
    s_wrdata_c = '0;
    s_wren_c   = 1'b0;
    key_addr_c = '0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      INIT: begin
        s_addr_c   = i_q[ADDR_W-1:0];
        s_wrdata_c = i_q[ADDR_W-1:0];
        s_wren_c   = 1'b1;
        busy_c     = 1'b1;
      end
      RD_SI: begin
        s_addr_c   = i_q[ADDR_W-1:0];
        key_addr_c = k_q;
        busy_c     = 1'b1;
      end
      STR_SI_J: busy_c = 1'b1;
      RD_SJ: begin
        s_addr_c = j_q;
        busy_c   = 1'b1;
      end
      STR_SJ_WR_SI: begin
        s_addr_c   = j_q;
        s_wrdata_c = si_q;
        s_wren_c   = 1'b1;
        busy_c     = 1'b1;
      end
      WR_SJ: begin
        s_addr_c   = i_q[ADDR_W-1:0];
        s_wrdata_c = sj_q;
        s_wren_c   = 1'b1;
        busy_c     = 1'b1;
      end
      NEXT: busy_c = 1'b1;
      DONE: done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.s_addr   = s_addr_c;
  assign bus.s_wrdata = s_wrdata_c;
  assign bus.s_wren   = s_wren_c;
  assign bus.key_addr = key_addr_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
endmodule

// File: tb/tb_ksa_shuffle_engine.sv
// Bench for ksa_shuffle_engine: an N=8 and an N=256 instance with behavioural memories,
// a cycle-level KSA model feeding one compare process, plus literal result pins.
module tb_ksa_shuffle_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ksa_shuffle_engine_if #(.ADDR_W(3), .KEY_W(3), .KLW(3)) bus_a ();
  ksa_shuffle_engine_if #(.ADDR_W(8), .KEY_W(8), .KLW(6)) bus_b ();

  ksa_shuffle_engine #(.ADDR_W(3), .KEY_W(3), .KEY_LEN_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master));
  ksa_shuffle_engine #(.ADDR_W(8), .KEY_W(8), .KEY_LEN_MAX(32)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master));

  logic [7:0] mem_a [8];
  logic [7:0] key_a [8];
  logic [7:0] mem_b [256];
  logic [7:0] key_b [64];
  bit         fill_a;

  // One-cycle-latency S and key memories for both instances.
  always @(posedge clk) begin
    if (fill_a) begin
      for (int n = 0; n < 8; n++) mem_a[n] <= 8'(n);
    end else if (bus_a.s_wren) begin
      mem_a[bus_a.s_addr] <= 8'(bus_a.s_wrdata);
    end
    bus_a.s_rddata <= 3'(mem_a[bus_a.s_addr]);
    bus_a.key_data <= 3'(key_a[bus_a.key_addr]);
    if (bus_b.s_wren) mem_b[bus_b.s_addr] <= bus_b.s_wrdata;
    bus_b.s_rddata <= mem_b[bus_b.s_addr];
    bus_b.key_data <= key_b[bus_b.key_addr];
  end

  bit sel;
  logic [7:0] o_addr, o_wdata, o_kaddr;
  logic       o_wren, o_busy, o_done;
  assign o_addr  = sel ? bus_b.s_addr   : 8'(bus_a.s_addr);
  assign o_wdata = sel ? bus_b.s_wrdata : 8'(bus_a.s_wrdata);
  assign o_kaddr = sel ? 8'(bus_b.key_addr) : 8'(bus_a.key_addr);
  assign o_wren  = sel ? bus_b.s_wren : bus_a.s_wren;
  assign o_busy  = sel ? bus_b.busy   : bus_a.busy;
  assign o_done  = sel ? bus_b.done   : bus_a.done;

  typedef struct {
    bit wren; bit busy; bit done;
    bit ca; int addr;
    bit cw; int wdata;
    bit ck; int kaddr;
  } rec_t;

  rec_t exp_q[$];
  int   m_s   [256];
  int   m_key [64];
  int   sw_s  [256];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(bit wren, bit busy, bit done, bit ca, int addr,
                              bit cw, int wdata, bit ck, int kaddr);
    rec_t r;
    r.wren = wren; r.busy = busy; r.done = done;
    r.ca = ca; r.addr = addr; r.cw = cw; r.wdata = wdata; r.ck = ck; r.kaddr = kaddr;
    return r;
  endfunction

  // Expected port activity per cycle after the start edge, from the plain KSA algorithm.
  task automatic model_run(input bit init, input int klen_raw, input int aw, input int klm,
                           input int n_idle);
    int n, eff, j, k, si, sj;
    n   = 1 << aw;
    eff = (klen_raw == 0) ? 1 : ((klen_raw > klm) ? klm : klen_raw);
    exp_q.delete();
    if (init) begin
      for (int i = 0; i < n; i++) begin
        m_s[i] = i;
        exp_q.push_back(mk(1, 1, 0, 1, i, 1, i, 0, 0));
      end
    end
    j = 0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(0, 1, 0, 1, i, 0, 0, 1, k));
      si = m_s[i];
      j  = (j + si + m_key[k]) % n;
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 1, 0, 1, j, 0, 0, 0, 0));
      sj = m_s[j];
      exp_q.push_back(mk(1, 1, 0, 1, j, 1, si, 0, 0));
      exp_q.push_back(mk(1, 1, 0, 1, i, 1, sj, 0, 0));
      m_s[j] = si;
      m_s[i] = sj;
      k = (k + 1) % eff;
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int q = 0; q < n_idle; q++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Untimed reference KSA on sw_s with the current key.
  function automatic void sw_ksa(input int n, input int len);
    int j, t;
    j = 0;
    for (int i = 0; i < n; i++) begin
      j = (j + sw_s[i] + m_key[i % len]) % n;
      t = sw_s[i]; sw_s[i] = sw_s[j]; sw_s[j] = t;
    end
  endfunction

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("s_wren", 32'(o_wren), 32'(r.wren));
        check("busy", 32'(o_busy), 32'(r.busy));
        check("done", 32'(o_done), 32'(r.done));
        if (r.ca) check("s_addr", 32'(o_addr), 32'(r.addr));
        if (r.cw) check("s_wrdata", 32'(o_wdata), 32'(r.wdata));
        if (r.ck) check("key_addr", 32'(o_kaddr), 32'(r.kaddr));
      end
    end
  end

  task automatic set_start(input bit s, input bit v);
    if (s) bus_b.start = v; else bus_a.start = v;
  endtask

  task automatic run(input bit s, input bit init, input int klen, input bit spam,
                     input int n_idle, output int done_edge, output int busy_cnt,
                     output int done_cnt);
    int aw, klm, n, total;
    aw    = s ? 8 : 3;
    klm   = s ? 32 : 4;
    n     = 1 << aw;
    total = (init ? n : 0) + 6 * n;
    @(negedge clk);
    sel = s;
    for (int q = 0; q < n; q++) m_s[q] = s ? int'(mem_b[q]) : int'(mem_a[q]);
    for (int q = 0; q < 64; q++) m_key[q] = s ? int'(key_b[q]) : ((q < 8) ? int'(key_a[q]) : 0);
    if (s) begin
      bus_b.init_en = init; bus_b.key_len = 6'(klen);
    end else begin
      bus_a.init_en = init; bus_a.key_len = 3'(klen);
    end
    set_start(s, 1'b1);
    @(posedge clk);
    model_run(init, klen, aw, klm, n_idle);
    busy_cnt  = 0;
    done_cnt  = 0;
    done_edge = -1;
    for (int c = 1; c <= total + 1 + n_idle; c++) begin
      @(negedge clk);
      set_start(s, spam && (c <= total));
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        done_edge = c - 1;
      end
    end
  endtask

  task automatic check_s_a();
    int exp_s [8];
    exp_s = '{0, 3, 6, 4, 5, 1, 2, 7};
    for (int q = 0; q < 8; q++) check("S_a_literal", 32'(mem_a[q]), 32'(exp_s[q]));
  endtask

  task automatic check_s_b_model();
    for (int q = 0; q < 256; q++) check("S_b_model", 32'(mem_b[q]), 32'(m_s[q]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_addr"}, 32'(o_addr), 0);
    check({tag, "_s_wrdata"}, 32'(o_wdata), 0);
    check({tag, "_s_wren"}, 32'(o_wren), 0);
    check({tag, "_key_addr"}, 32'(o_kaddr), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
  endtask

  initial begin
    int de, bc, dc;
    int p [256];
    int pi, pj, t;
    int ks_exp [4];
    ks_exp = '{32'hEB, 32'h9F, 32'h77, 32'h81};
    sel = 0;
    fill_a = 0;
    bus_a.start = 0; bus_a.init_en = 0; bus_a.key_len = '0;
    bus_b.start = 0; bus_b.init_en = 0; bus_b.key_len = '0;
    for (int q = 0; q < 8; q++) key_a[q] = 8'h00;
    key_a[0] = 8'd1;
    key_a[1] = 8'd2;
    for (int q = 0; q < 64; q++) key_b[q] = 8'h00;
    key_b[0] = 8'h4B; key_b[1] = 8'h65; key_b[2] = 8'h79;

    rst = 0;
    #1 rst = 1;
    #1;
    sel = 0; #0 check_outputs_zero("reset_a");
    sel = 1; #0 check_outputs_zero("reset_b");
    @(negedge clk);
    rst = 0;

    // N=8 with identity fill, key [1,2]; then an immediate restart while start is hammered.
    run(0, 1, 2, 0, 0, de, bc, dc);
    check("a1_done_edge", 32'(de), 56);
    check("a1_busy_cycles", 32'(bc), 56);
    check("a1_done_pulses", 32'(dc), 1);
    check_s_a();
    run(0, 1, 2, 1, 2, de, bc, dc);
    check("a2_done_pulses", 32'(dc), 1);
    check("a2_done_edge", 32'(de), 56);
    check_s_a();

    // Identity preloaded, no fill.
    @(negedge clk) fill_a = 1;
    @(negedge clk) fill_a = 0;
    run(0, 0, 2, 0, 1, de, bc, dc);
    check("a3_done_edge", 32'(de), 48);
    check("a3_busy_cycles", 32'(bc), 48);
    check_s_a();

    // Asynchronous reset during the first STR_SJ_WR_SI, then a clean re-run.
    @(negedge clk);
    sel = 0;
    bus_a.init_en = 1; bus_a.key_len = 3'd2; bus_a.start = 1;
    @(posedge clk);
    @(negedge clk) bus_a.start = 0;
    repeat (11) @(posedge clk);
    #2;
    check("pre_reset_s_wren", 32'(o_wren), 1);
    rst = 1;
    #1;
    check_outputs_zero("midrun_reset");
    @(negedge clk) rst = 0;
    run(0, 1, 2, 0, 1, de, bc, dc);
    check("a4_done_edge", 32'(de), 56);
    check_s_a();

    // N=256, key "Key" with fill; keystream pins the final permutation.
    run(1, 1, 3, 0, 1, de, bc, dc);
    check("b1_done_edge", 32'(de), 1792);
    check_s_b_model();
    for (int q = 0; q < 256; q++) p[q] = int'(mem_b[q]);
    pi = 0; pj = 0;
    for (int b = 0; b < 4; b++) begin
      pi = (pi + 1) % 256;
      pj = (pj + p[pi]) % 256;
      t = p[pi]; p[pi] = p[pj]; p[pj] = t;
      check("b1_prga_byte", 32'(p[(p[pi] + p[pj]) % 256]), 32'(ks_exp[b]));
    end

    // key_len=0 acts as a single key byte, starting from the current S contents.
    for (int q = 0; q < 256; q++) sw_s[q] = int'(mem_b[q]);
    run(1, 0, 0, 0, 1, de, bc, dc);
    check("b2_done_edge", 32'(de), 1536);
    check_s_b_model();
    sw_ksa(256, 1);
    for (int q = 0; q < 256; q++) check("b2_S_len1", 32'(mem_b[q]), 32'(sw_s[q]));

    // Oversize key_len clamps to the 32-byte maximum; bytes past it must never be used.
    for (int q = 0; q < 64; q++) key_b[q] = 8'($urandom_range(0, 255));
    run(1, 1, 37, 0, 1, de, bc, dc);
    check("b3_done_edge", 32'(de), 1792);
    check_s_b_model();
    for (int q = 0; q < 256; q++) sw_s[q] = q;
    sw_ksa(256, 32);
    for (int q = 0; q < 256; q++) check("b3_S_len32", 32'(mem_b[q]), 32'(sw_s[q]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
